// File: rtl/ah_div_pkg.sv
// Shared types and defaults for the divider issue scheduler.
// The tag index is sized for the largest supported requester count (8).
package ah_div_pkg;
  localparam int STAGES    = 16;
  localparam int LAT_DEF   = STAGES + 1;
  localparam int WIDTH_DEF = 50;
  localparam int IDX_W     = 3;

  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
  } tag_t;
endpackage

// File: rtl/ah_rr_arbiter.sv
// Round-robin one-hot arbiter with an internal rotating pointer.
// The pointer moves to one past the winner only on a grant.
module ah_rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx,
  output logic            gnt_any
);
  logic [IW-1:0] ptr_q, ptr_d;

  always_comb begin
    logic [IW-1:0] sel;
    sel     = '0;
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int off = 0; off < NREQ; off++) begin
      sel = IW'((int'(ptr_q) + off) % NREQ);
      if (en && !gnt_any && req[sel]) begin
        gnt[sel] = 1'b1;
        gnt_idx  = sel;
        gnt_any  = 1'b1;
      end
    end
    ptr_d = ptr_q;
    if (gnt_any) ptr_d = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
endmodule

// File: rtl/ah_div_sched.sv
// Arbitrates NREQ requesters onto one fixed-latency pipelined divider and
// routes each result back to its issuer using a tag shift register.
module ah_div_sched
  import ah_div_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEF,
  parameter  int NREQ  = 4,
  parameter  int LAT   = LAT_DEF,
  localparam int IW    = $clog2(NREQ),
  localparam int CW    = $clog2(LAT + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_dividend,
  input  logic [NREQ*WIDTH-1:0] req_divisor,
  output logic                  div_start,
  output logic [WIDTH-1:0]      div_dividend,
  output logic [WIDTH-1:0]      div_divisor,
  input  logic                  div_data_valid,
  input  logic [WIDTH-1:0]      div_quotient,
  input  logic                  div_by_zero,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]      rsp_quotient,
  output logic                  rsp_div_by_zero,
  output logic [CW-1:0]         inflight,
  output logic                  idle,
  output logic                  err_orphan
);
  logic [NREQ-1:0]     gnt;
  logic [IW-1:0]       gnt_idx;
  logic                gnt_any;
  tag_t [LAT-1:0]      tag_q, tag_d;
  tag_t                tag_out;
  logic                retire;
  logic [CW-1:0]       inflight_q, inflight_d;
  logic                err_orphan_q, err_orphan_d;

  // Gating with rst_n keeps grants off while reset is asserted.
  ah_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (enable & rst_n),
    .req     (req_valid),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign req_ready = gnt;
  assign div_start = gnt_any;

  always_comb begin
    div_dividend = '0;
    div_divisor  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        div_dividend = req_dividend[i*WIDTH +: WIDTH];
        div_divisor  = req_divisor[i*WIDTH +: WIDTH];
      end
    end
  end

  // Tag entry k is visible k+1 cycles after issue, so the last entry lines
  // up with the divider's data_valid exactly LAT cycles after div_start.
  always_comb begin
    tag_d[0].vld = gnt_any;
    tag_d[0].idx = IDX_W'(gnt_idx);
    for (int k = 1; k < LAT; k++) tag_d[k] = tag_q[k-1];
  end

  assign tag_out = tag_q[LAT-1];
  assign retire  = tag_out.vld & div_data_valid;

  always_comb begin
    for (int i = 0; i < NREQ; i++) rsp_valid[i] = retire && (tag_out.idx == IDX_W'(i));
  end

  assign rsp_quotient    = div_quotient;
  assign rsp_div_by_zero = div_by_zero;

  always_comb begin
    inflight_d = inflight_q;
    if (gnt_any && !retire && inflight_q != CW'(LAT))
      inflight_d = inflight_q + CW'(1);
    else if (!gnt_any && retire && inflight_q != '0)
      inflight_d = inflight_q - CW'(1);
    err_orphan_d = err_orphan_q | (tag_out.vld != div_data_valid);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q        <= '0;
      inflight_q   <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      tag_q        <= tag_d;
      inflight_q   <= inflight_d;
      err_orphan_q <= err_orphan_d;
    end
  end

  assign inflight   = inflight_q;
  assign err_orphan = err_orphan_q;
  assign idle       = !rst_n || (inflight_q == '0 && req_valid == '0);
endmodule

// File: tb/tb_ah_div_sched.sv
// Scoreboard bench: issues push hand-computed results, a negedge monitor
// pops and compares every rsp_valid strobe including its arrival cycle.
module tb_ah_div_sched;
  localparam int W = 50, N = 4, L = 17;

  logic             clk = 1'b0, rst_n = 1'b0, enable = 1'b0, spur = 1'b0;
  logic [N-1:0]     req_valid = '0, req_ready, rsp_valid;
  logic [N*W-1:0]   req_dividend = '0, req_divisor = '0;
  logic             div_start, div_data_valid, div_by_zero, rsp_div_by_zero, idle, err_orphan;
  logic [W-1:0]     div_dividend, div_divisor, div_quotient, rsp_quotient;
  logic [4:0]       inflight;
  int               n_chk = 0, n_fail = 0, cyc = 0;

  typedef struct {
    logic [N-1:0] oh;
    logic [W-1:0] q;
    logic         z;
    int           cyc;
  } exp_t;
  exp_t sbq[$];

  logic signed [63:0] rr_a [4] = '{64'sd1000, -64'sd1000, 64'sd77, 64'sd1099511627776};
  logic signed [63:0] rr_b [4] = '{64'sd3, 64'sd7, -64'sd5, 64'sd1024};
  logic signed [63:0] rr_q [4] = '{64'sd333, -64'sd142, -64'sd15, 64'sd1073741824};

  ah_div_sched #(.WIDTH(W), .NREQ(N), .LAT(L)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor), .div_start(div_start),
    .div_dividend(div_dividend), .div_divisor(div_divisor), .div_data_valid(div_data_valid),
    .div_quotient(div_quotient), .div_by_zero(div_by_zero), .rsp_valid(rsp_valid),
    .rsp_quotient(rsp_quotient), .rsp_div_by_zero(rsp_div_by_zero), .inflight(inflight),
    .idle(idle), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in pipelined divider: L stages, quotient 0 on divide-by-zero.
  typedef struct packed { logic v; logic [W-1:0] q; logic z; } dst_t;
  dst_t dp [L];
  logic signed [W-1:0] sa, sb;
  logic [W-1:0] mq;
  assign sa = div_dividend;
  assign sb = div_divisor;
  assign mq = (sb == 0) ? '0 : W'(sa / sb);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < L; k++) dp[k] <= '0;
    end else begin
      dp[0] <= '{v: div_start, q: mq, z: (sb == 0)};
      for (int k = 1; k < L; k++) dp[k] <= dp[k-1];
    end
  end
  assign div_data_valid = dp[L-1].v | spur;
  assign div_quotient   = dp[L-1].q;
  assign div_by_zero    = dp[L-1].z;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (rsp_valid != '0) begin
      if (sbq.size() == 0) check("rsp_unexpected", 64'(rsp_valid), 64'd0);
      else begin
        e = sbq.pop_front();
        n_chk++;
        if (rsp_valid !== e.oh || rsp_quotient !== e.q || rsp_div_by_zero !== e.z || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL rsp: got oh=%b q=%0d z=%b cyc=%0d expected oh=%b q=%0d z=%b cyc=%0d",
                   rsp_valid, $signed(rsp_quotient), rsp_div_by_zero, cyc,
                   e.oh, $signed(e.q), e.z, e.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic signed [63:0] a, input logic signed [63:0] b);
    req_dividend[i*W +: W] = a[W-1:0];
    req_divisor[i*W +: W]  = b[W-1:0];
  endtask

  // Called at the negedge of the cycle the grant is expected.
  task automatic expect_issue(input logic [N-1:0] g, input logic signed [63:0] a,
                              input logic signed [63:0] q, input logic z, input string nm);
    check({nm, "_ready"}, 64'(req_ready), 64'(g));
    check({nm, "_start"}, 64'(div_start), 64'd1);
    check({nm, "_dvd"}, 64'(div_dividend), 64'(a[W-1:0]));
    sbq.push_back('{oh: g, q: q[W-1:0], z: z, cyc: cyc + L});
  endtask

  task automatic do_reset();
    tick(); rst_n = 1'b0; req_valid = '0; spur = 1'b0;
    tick(); tick(); rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    enable = 1'b1; req_valid = '1; rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_start", 64'(div_start), 64'd0);
    check("rst_rsp", 64'(rsp_valid), 64'd0);
    check("rst_idle", 64'(idle), 64'd1);
    check("rst_inflight", 64'(inflight), 64'd0);
    check("rst_orphan", 64'(err_orphan), 64'd0);
    tick(); rst_n = 1'b1; req_valid = '0;

    // single op from requester 0
    tick(); set_op(0, 100, 7); req_valid = 4'b0001;
    @(negedge clk); expect_issue(4'b0001, 100, 14, 1'b0, "single");
    tick(); req_valid = '0;
    @(negedge clk); check("single_inflight1", 64'(inflight), 64'd1);
    repeat (17) tick();
    @(negedge clk);
    check("single_inflight0", 64'(inflight), 64'd0);
    check("single_idle", 64'(idle), 64'd1);

    // round robin, all four held valid for 8 cycles
    do_reset();
    for (int i = 0; i < 4; i++) set_op(i, rr_a[i], rr_b[i]);
    for (int k = 0; k < 8; k++) begin
      tick(); req_valid = '1;
      @(negedge clk);
      expect_issue(4'(1 << (k % 4)), rr_a[k%4], rr_q[k%4], 1'b0, "rr");
    end
    tick(); req_valid = '0;
    repeat (20) tick();

    // sustained issue + retire: (3k+1)/3 = k
    for (int k = 0; k < 57; k++) begin
      tick(); req_valid = 4'b0001; set_op(0, 64'(3 * k + 1), 3);
      @(negedge clk);
      expect_issue(4'b0001, 64'(3 * k + 1), 64'(k), 1'b0, "sus");
      check("sus_inflight", 64'(inflight), 64'((k < 17) ? k : 17));
    end
    tick(); req_valid = '0;
    repeat (17) tick();
    @(negedge clk); check("sus_drain", 64'(inflight), 64'd0);

    // enable low stalls grants while the in-flight op drains
    tick(); set_op(1, 500, -25); req_valid = 4'b0010;
    @(negedge clk); expect_issue(4'b0010, 500, -20, 1'b0, "en_pre");
    tick(); enable = 1'b0; req_valid = '1;
    for (int j = 0; j < 20; j++) begin
      if (j > 0) tick();
      @(negedge clk);
      check("en_ready", 64'(req_ready), 64'd0);
      check("en_start", 64'(div_start), 64'd0);
      check("en_dvd", 64'(div_dividend), 64'd0);
      check("en_idle", 64'(idle), 64'd0);
    end
    check("en_inflight", 64'(inflight), 64'd0);
    tick(); enable = 1'b1; req_valid = '0;

    // divide by zero from requester 2
    tick(); set_op(2, 55, 0); req_valid = 4'b0100;
    @(negedge clk); expect_issue(4'b0100, 55, 0, 1'b1, "dbz");
    tick(); req_valid = '0;
    repeat (17) tick();
    @(negedge clk);
    check("dbz_inflight", 64'(inflight), 64'd0);
    check("pre_orphan", 64'(err_orphan), 64'd0);

    // reset with ops in flight discards them; spurious result flags orphan
    for (int k = 0; k < 3; k++) begin
      tick(); req_valid = '1;
      @(negedge clk); check("rstfl_start", 64'(div_start), 64'd1);
    end
    tick(); req_valid = '0;
    repeat (4) tick();
    rst_n = 1'b0;
    tick(); tick(); rst_n = 1'b1;
    repeat (25) tick();
    @(negedge clk);
    check("rstfl_orphan0", 64'(err_orphan), 64'd0);
    check("rstfl_inflight", 64'(inflight), 64'd0);
    tick(); spur = 1'b1;
    @(negedge clk); check("spur_rsp", 64'(rsp_valid), 64'd0);
    tick(); spur = 1'b0;
    @(negedge clk); check("spur_orphan", 64'(err_orphan), 64'd1);
    repeat (10) tick();
    @(negedge clk); check("spur_sticky", 64'(err_orphan), 64'd1);
    do_reset();
    @(negedge clk); check("spur_cleared", 64'(err_orphan), 64'd0);

    for (int j = 0; j < 50 && sbq.size() != 0; j++) tick();
    check("sb_empty", 64'(sbq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
